// File: rtl/tlp_txpd_fifo.sv
// Store-and-forward FIFO for outbound posted TLPs. A packet is released to the TX stream only
// once it is fully written and the core grants posted credit.
module tlp_txpd_fifo #(
    parameter int unsigned C_DATA_WIDTH = 64,
    parameter int unsigned C_DEPTH_LOG2 = 9,
    parameter int unsigned C_PKT_CNT_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [C_DATA_WIDTH-1:0] wr_data,
    input  logic [7:0]              wr_keep,
    input  logic                    wr_last,
    input  logic                    wr_abort,
    input  logic                    pd_credit_ok,
    output logic                    tx_tvalid,
    input  logic                    tx_tready,
    output logic [C_DATA_WIDTH-1:0] tx_tdata,
    output logic [7:0]              tx_tkeep,
    output logic                    tx_tlast,
    output logic [C_PKT_CNT_W-1:0]  pkt_cnt,
    output logic [C_DEPTH_LOG2:0]   free_words
);
    localparam int unsigned DEPTH = 1 << C_DEPTH_LOG2;
    localparam int unsigned MEM_W = C_DATA_WIDTH + 2;
    localparam logic [C_DEPTH_LOG2:0] DEPTH_W = {1'b1, {C_DEPTH_LOG2{1'b0}}};

    typedef enum logic {StIdle, StSend} state_t;

    // Entry layout: {data, keep_lo, last}; keep_lo marks an 8'h0F final beat.
    logic [MEM_W-1:0]        r_mem [DEPTH];
    logic [MEM_W-1:0]        r_ram_q;
    logic                    r_ram_vld;
    logic [C_DEPTH_LOG2:0]   r_wr_ptr;
    logic [C_DEPTH_LOG2:0]   r_wr_commit;
    logic [C_DEPTH_LOG2:0]   r_rd_ptr;
    logic [C_PKT_CNT_W-1:0]  r_pkt_cnt;
    state_t                  r_state;
    logic                    r_rd_done;
    logic                    r_v0;
    logic                    r_v1;
    logic [C_DATA_WIDTH-1:0] r_b0_data;
    logic [C_DATA_WIDTH-1:0] r_b1_data;
    logic [7:0]              r_b0_keep;
    logic [7:0]              r_b1_keep;
    logic                    r_b0_last;
    logic                    r_b1_last;

    logic [C_DEPTH_LOG2:0]   w_used;
    logic                    w_wr_acc;
    logic                    w_commit;
    logic                    w_pop;
    logic                    w_tlast_hs;
    logic                    w_rd_en;
    logic                    w_ram_hit_last;
    logic [C_DATA_WIDTH-1:0] w_ram_data;
    logic [7:0]              w_ram_keep;
    logic                    w_ram_last;
    logic [1:0]              w_level;

    assign w_used     = r_wr_ptr - r_rd_ptr;
    assign wr_ready   = !rst && !w_used[C_DEPTH_LOG2] && !(&r_pkt_cnt);
    assign w_wr_acc   = wr_valid && wr_ready;
    assign w_commit   = w_wr_acc && wr_last && !wr_abort;
    assign w_pop      = r_v0 && tx_tready;
    assign w_tlast_hs = w_pop && r_b0_last;
    assign free_words = DEPTH_W - w_used;
    assign pkt_cnt    = r_pkt_cnt;

    assign tx_tvalid = r_v0;
    assign tx_tdata  = r_b0_data;
    assign tx_tkeep  = r_b0_keep;
    assign tx_tlast  = r_b0_last;

    assign w_ram_data     = r_ram_q[MEM_W-1:2];
    assign w_ram_keep     = r_ram_q[1] ? 8'h0F : 8'hFF;
    assign w_ram_last     = r_ram_q[0];
    assign w_ram_hit_last = r_ram_vld && w_ram_last;

    // Beats buffered plus one in RAM flight, after this cycle's pop.
    assign w_level = {1'b0, r_v0} + {1'b0, r_v1} + {1'b0, r_ram_vld} - {1'b0, w_pop};

    // Reads stop as soon as the last beat is seen so the next packet is never over-read.
    always_comb begin
        w_rd_en = 1'b0;
        if (r_state == StIdle) begin
            w_rd_en = (r_pkt_cnt != '0) && pd_credit_ok;
        end else begin
            w_rd_en = !r_rd_done && !w_ram_hit_last && (w_level <= 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[C_DEPTH_LOG2-1:0]] <= {wr_data, wr_keep == 8'h0F, wr_last};
        end
        if (w_rd_en) begin
            r_ram_q <= r_mem[r_rd_ptr[C_DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
        end else if (wr_abort) begin
            r_wr_ptr <= r_wr_commit;
        end else if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (wr_last) begin
                r_wr_commit <= r_wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt <= '0;
        end else if (w_commit && !w_tlast_hs) begin
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
        end else if (!w_commit && w_tlast_hs) begin
            r_pkt_cnt <= r_pkt_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_rd_done <= 1'b0;
            r_rd_ptr  <= '0;
            r_ram_vld <= 1'b0;
        end else begin
            r_ram_vld <= w_rd_en;
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (w_rd_en) begin
                        r_state   <= StSend;
                        r_rd_done <= 1'b0;
                    end
                end
                StSend: begin
                    if (w_ram_hit_last) begin
                        r_rd_done <= 1'b1;
                    end
                    if (w_tlast_hs) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Two-entry prefetch: b0 drives the stream, b1 catches the beat already in RAM flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0      <= 1'b0;
            r_v1      <= 1'b0;
            r_b0_data <= '0;
            r_b0_keep <= '0;
            r_b0_last <= 1'b0;
            r_b1_data <= '0;
            r_b1_keep <= '0;
            r_b1_last <= 1'b0;
        end else if (w_pop) begin
            if (r_v1) begin
                r_b0_data <= r_b1_data;
                r_b0_keep <= r_b1_keep;
                r_b0_last <= r_b1_last;
                r_v1      <= r_ram_vld;
                if (r_ram_vld) begin
                    r_b1_data <= w_ram_data;
                    r_b1_keep <= w_ram_keep;
                    r_b1_last <= w_ram_last;
                end
            end else if (r_ram_vld) begin
                r_b0_data <= w_ram_data;
                r_b0_keep <= w_ram_keep;
                r_b0_last <= w_ram_last;
            end else begin
                r_v0 <= 1'b0;
            end
        end else if (r_ram_vld) begin
            if (!r_v0) begin
                r_v0      <= 1'b1;
                r_b0_data <= w_ram_data;
                r_b0_keep <= w_ram_keep;
                r_b0_last <= w_ram_last;
            end else begin
                r_v1      <= 1'b1;
                r_b1_data <= w_ram_data;
                r_b1_keep <= w_ram_keep;
                r_b1_last <= w_ram_last;
            end
        end
    end

endmodule

// File: doc/tlp_txpd_fifo.md
Name: tlp_txpd_fifo

Overview:
Store-and-forward FIFO for outbound posted TLPs (memory writes: header + payload) between the AXI-slave write engine and the PCIe core TX AXI-Stream port. It is the transmit-direction counterpart of the RX posted-data FIFO. A packet becomes visible to the TX side only after its last beat is written. Transmission of each packet starts only when the core reports posted credit available.

Parameters:
C_DATA_WIDTH, 64, datapath width in bits (only 64 supported)
C_DEPTH_LOG2, 9, log2 of storage depth in beats (512 beats)
C_PKT_CNT_W, 5, width of the committed-packet counter (max 2^C_PKT_CNT_W-1 = 31 packets)

Ports:
clk  in  1  core clock (user_clk)
rst  in  1  synchronous reset, active-high
wr_valid  in  1  write beat valid
wr_ready  out  1  FIFO can accept a beat
wr_data  in  64  TLP beat (header DWs first)
wr_keep  in  8  byte enables; legal values 8'hFF, and 8'h0F on the last beat only
wr_last  in  1  last beat of the TLP
wr_abort  in  1  single-cycle pulse: discard the uncommitted packet in progress
pd_credit_ok  in  1  core has posted header and data credit for one max-size TLP
tx_tvalid  out  1  TX stream valid
tx_tready  in  1  TX stream ready
tx_tdata  out  64  TX beat
tx_tkeep  out  8  8'hFF or 8'h0F
tx_tlast  out  1  end of TLP
pkt_cnt  out  C_PKT_CNT_W  committed packets not yet fully sent
free_words  out  C_DEPTH_LOG2+1  free beat slots (write-pointer view)

Behaviour:
- Reset: pointers, pkt_cnt and state are cleared. tx_tvalid=0, tx_tlast=0, tx_tdata=0, tx_tkeep=0, wr_ready=0 while rst=1. free_words=2^C_DEPTH_LOG2. wr_ready rises the first cycle after rst deasserts.
- Storage: dual-port RAM of {data, keep_lo, last}, where keep_lo=1 means 8'h0F. Pointers are C_DEPTH_LOG2+1 bits wide; the extra wrap bit distinguishes full from empty.
- Write side: a beat is accepted when wr_valid && wr_ready.
  - wr_ready = !full && pkt_cnt != max.
  - wr_ptr advances on each accepted beat. wr_commit (the commit pointer) is set to wr_ptr+1 on an accepted beat with wr_last=1.
  - The pkt_cnt increment from a commit is visible the next cycle.
- Abort: on wr_abort, wr_ptr returns to wr_commit the next cycle. If wr_abort coincides with an accepted wr_last beat, abort wins: nothing is committed and pkt_cnt is unchanged. wr_abort with no packet in progress is a no-op.
- Full: when the FIFO fills mid-packet, wr_ready=0 and the writer stalls. A packet larger than the depth must be aborted by the writer; the FIFO never deadlocks internally.
- Read FSM:
  - IDLE: if pkt_cnt!=0 && pd_credit_ok, go to SEND and issue the RAM read of the first beat.
  - SEND: stream beats through a 2-entry prefetch buffer. Go back to IDLE on tx_tvalid && tx_tready && tx_tlast.
  - Credit is sampled only in IDLE. Deassertion of pd_credit_ok during SEND does not stall the packet.
- Latency: wr_last accepted in cycle N, pd_credit_ok=1 → tx_tvalid=1 in cycle N+3.
  - Within a packet, tx_tvalid stays high on every cycle after a handshake, i.e. no bubbles at tx_tready=1.
  - Gap between back-to-back packets is at most 2 cycles.
- AXI-Stream rules: once asserted, tx_tvalid and the data fields hold until tx_tready. tx_tvalid never depends combinationally on tx_tready.
- pkt_cnt decrements on the tlast handshake. A simultaneous commit and tlast handshake leaves pkt_cnt unchanged.
- free_words = depth - (wr_ptr - rd_ptr), with the RAM read pointer used for rd_ptr. Slots are freed as beats leave the RAM.
- Reset mid-operation: an in-flight TX packet is truncated and all contents are discarded. The TX side must tolerate a dropped tlast; that is accepted system behaviour on link reset.

Test Plan:
- Single MWr: 3 beats (hdr+addr, hdr DW3+data0, data1 with keep 8'h0F), credit=1, tready=1 → tx beats identical, tlast on beat 3 with tkeep 8'h0F, first tvalid at N+3, pkt_cnt 0→1→0.
- Abort: write 2 beats, pulse wr_abort, then write a 4-beat packet → only the 4-beat packet appears. free_words returns to 512 after it is sent.
- Abort+last collision: wr_abort asserted on the accepted wr_last beat → pkt_cnt stays 0, tx_tvalid stays 0, wr_ptr equals wr_commit.
- Full: tready=0, write 512 beats as 16×32-beat packets → wr_ready=0 after beat 512, free_words=0. Release tready → all 16 packets emerge in order, no bubbles inside packets.
- Credit gating: 2 packets committed, pd_credit_ok=0 for 20 cycles → tx_tvalid=0. Credit=1 for 1 cycle → packet 1 fully sent even with credit dropped; packet 2 waits for the next credit.
- Reset mid-packet: assert rst during beat 2 of 4 at the TX side → next cycle tx_tvalid=0, pkt_cnt=0, free_words=512. A new packet afterwards passes unchanged.
